pipe_reg_chain: RTL and testbench

//  Next-generation DSP48A1-slice input/output register. A WIDTH-bit shift chain of MAX_DEPTH

---
 rtl/pipe_reg_chain.sv | 76 +++++++
 tb/tb_pipe_reg_chain.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/pipe_reg_chain.sv
// Runtime-selectable delay line: WIDTH-bit data plus a valid bit through up to MAX_DEPTH stages,
// with a combinational bypass at latency 0 and a valid flush whenever the selected latency changes.
module pipe_reg_chain #(
    parameter int unsigned WIDTH     = 18,
    parameter int unsigned MAX_DEPTH = 4,
    parameter int unsigned SEL_W     = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [SEL_W-1:0] lat_sel,
    input  logic [WIDTH-1:0] in,
    input  logic             in_vld,
    output logic [WIDTH-1:0] out_mux,
    output logic             out_vld,
    output logic             lat_err
);

    logic [WIDTH-1:0] r_stage [1:MAX_DEPTH];
    logic             r_vld   [1:MAX_DEPTH];
    logic [SEL_W-1:0] r_lat_q;
    logic [SEL_W-1:0] w_lat_eff;
    logic             w_lat_err;
    logic             w_flush;

    // Out-of-range requests saturate to the deepest tap.
    always_comb begin
        w_lat_err = (lat_sel > SEL_W'(MAX_DEPTH));
        w_lat_eff = w_lat_err ? SEL_W'(MAX_DEPTH) : lat_sel;
        w_flush   = (w_lat_eff != r_lat_q);
    end

    assign lat_err = w_lat_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lat_q <= '0;
            for (int unsigned k = 1; k <= MAX_DEPTH; k++) begin
                r_stage[k] <= '0;
                r_vld[k]   <= 1'b0;
            end
        end else begin
            r_lat_q <= w_lat_eff;
            if (ce) begin
                r_stage[1] <= in;
                for (int unsigned k = 2; k <= MAX_DEPTH; k++) begin
                    r_stage[k] <= r_stage[k-1];
                end
            end
            // A latency change invalidates everything in flight, including this cycle's input.
            if (w_flush) begin
                for (int unsigned k = 1; k <= MAX_DEPTH; k++) begin
                    r_vld[k] <= 1'b0;
                end
            end else if (ce) begin
                r_vld[1] <= in_vld;
                for (int unsigned k = 2; k <= MAX_DEPTH; k++) begin
                    r_vld[k] <= r_vld[k-1];
                end
            end
        end
    end

    // Tap select on the registered latency; 0 is the bypass path.
    always_comb begin
        out_mux = in;
        out_vld = in_vld;
        for (int unsigned k = 1; k <= MAX_DEPTH; k++) begin
            if (r_lat_q == SEL_W'(k)) begin
                out_mux = r_stage[k];
                out_vld = r_vld[k];
            end
        end
    end

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed bench for pipe_reg_chain (WIDTH=18, MAX_DEPTH=4): bypass, tap latency, ce stalls,
// valid flush on latency change, out-of-range saturation and mid-stream reset.
module tb_pipe_reg_chain;

    localparam int unsigned WIDTH     = 18;
    localparam int unsigned MAX_DEPTH = 4;
    localparam int unsigned SEL_W     = 3;

    logic             clk;
    logic             rst;
    logic             ce;
    logic [SEL_W-1:0] lat_sel;
    logic [WIDTH-1:0] tb_in;
    logic             in_vld;
    logic [WIDTH-1:0] out_mux;
    logic             out_vld;
    logic             lat_err;

    int n_pass  = 0;
    int n_total = 0;

    pipe_reg_chain #(
        .WIDTH    (WIDTH),
        .MAX_DEPTH(MAX_DEPTH),
        .SEL_W    (SEL_W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .ce     (ce),
        .lat_sel(lat_sel),
        .in     (tb_in),
        .in_vld (in_vld),
        .out_mux(out_mux),
        .out_vld(out_vld),
        .lat_err(lat_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance one edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive data/valid, take one edge, then check the tap output.
    task automatic step(input logic [WIDTH-1:0] d, input logic v, input string tag,
                        input logic [WIDTH-1:0] exp_d, input logic exp_v);
        tb_in  = d;
        in_vld = v;
        tick();
        chk({tag, "_data"}, 32'(out_mux), 32'(exp_d));
        chk({tag, "_vld"},  32'(out_vld), 32'(exp_v));
    endtask

    initial begin
        rst     = 1'b1;
        ce      = 1'b0;
        lat_sel = '0;
        tb_in   = '0;
        in_vld  = 1'b0;
        tick();
        rst = 1'b0;

        // Reset state: bypass
        tb_in = 18'h155; in_vld = 1'b1; #1;
        chk("t1_bypass_data", 32'(out_mux), 32'h155);
        chk("t1_bypass_vld",  32'(out_vld), 32'd1);
        chk("t1_lat_err",     32'(lat_err), 32'd0);
        in_vld = 1'b0; #1;
        chk("t1_bypass_vld0", 32'(out_vld), 32'd0);

        // Latency 3: tap change lands one edge after lat_sel
        lat_sel = 3'd3; ce = 1'b1; tb_in = 18'h2AA; in_vld = 1'b1; #1;
        chk("t2_pre_bypass",  32'(out_mux), 32'h2AA);
        step(18'h2AA, 1'b1, "t2_flush", 18'h0,   1'b0);
        step(18'd1,   1'b1, "t2_e1",    18'h0,   1'b0);
        step(18'd2,   1'b1, "t2_e2",    18'h2AA, 1'b0);
        step(18'd3,   1'b1, "t2_e3",    18'd1,   1'b1);
        step(18'd4,   1'b1, "t2_e4",    18'd2,   1'b1);
        step(18'd5,   1'b1, "t2_e5",    18'd3,   1'b1);

        // Latency 2 with a two-cycle ce gap
        lat_sel = 3'd2;
        step(18'd10, 1'b1, "t3_flush", 18'd5,  1'b0);
        step(18'd11, 1'b1, "t3_s11",   18'd10, 1'b0);
        step(18'd12, 1'b1, "t3_s12",   18'd11, 1'b1);
        ce = 1'b0;
        step(18'd13, 1'b1, "t3_hold1", 18'd11, 1'b1);
        step(18'd13, 1'b1, "t3_hold2", 18'd11, 1'b1);
        ce = 1'b1;
        step(18'd13, 1'b1, "t3_res1",  18'd12, 1'b1);
        step(18'd14, 1'b1, "t3_res2",  18'd13, 1'b1);

        // Run at latency 4, then drop to 1: flush keeps data, clears valids
        lat_sel = 3'd4;
        step(18'd20, 1'b1, "t4_flush4", 18'd12, 1'b0);
        step(18'd21, 1'b1, "t4_s21",    18'd13, 1'b0);
        step(18'd22, 1'b1, "t4_s22",    18'd14, 1'b0);
        step(18'd23, 1'b1, "t4_s23",    18'd20, 1'b0);
        step(18'd24, 1'b1, "t4_s24",    18'd21, 1'b1);
        lat_sel = 3'd1;
        step(18'd25, 1'b1, "t4_flush1", 18'd25, 1'b0);
        step(18'd26, 1'b1, "t4_s26",    18'd26, 1'b1);

        // Out-of-range latency saturates to MAX_DEPTH
        lat_sel = 3'd7; #1;
        chk("t5_err7", 32'(lat_err), 32'd1);
        step(18'd30, 1'b1, "t5_flush", 18'd24, 1'b0);
        step(18'd31, 1'b1, "t5_s31",   18'd25, 1'b0);
        step(18'd32, 1'b1, "t5_s32",   18'd26, 1'b0);
        step(18'd33, 1'b1, "t5_s33",   18'd30, 1'b0);
        step(18'd34, 1'b1, "t5_s34",   18'd31, 1'b1);
        lat_sel = 3'd4; #1;
        chk("t5_err4", 32'(lat_err), 32'd0);
        step(18'd35, 1'b1, "t5_noflush", 18'd32, 1'b1);

        // Mid-stream reset at latency 3
        lat_sel = 3'd3;
        step(18'd40, 1'b1, "t6_flush", 18'd34, 1'b0);
        step(18'd41, 1'b1, "t6_s41",   18'd35, 1'b0);
        step(18'd42, 1'b1, "t6_s42",   18'd40, 1'b0);
        step(18'd43, 1'b1, "t6_s43",   18'd41, 1'b1);
        rst = 1'b1;
        step(18'd44, 1'b1, "t6_rst",   18'd44, 1'b1);
        rst = 1'b0;
        tb_in = 18'd45; in_vld = 1'b0; #1;
        chk("t6_bypass_vld0", 32'(out_vld), 32'd0);
        step(18'd45, 1'b1, "t6_relat", 18'd0,  1'b0);
        step(18'd46, 1'b1, "t6_s46",   18'd0,  1'b0);
        step(18'd47, 1'b1, "t6_s47",   18'd45, 1'b0);
        step(18'd48, 1'b1, "t6_s48",   18'd46, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
